// File: rtl/ps2_defs.sv
// Shared scan-code, ASCII and FSM definitions for the PS/2 Set-2 decoder.
package ps2_defs;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  // Modifier / special make codes
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // ASCII constants
  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Prefix tracking: IDLE, F0 seen, E0 seen, E0 F0 seen
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational Set-2 make-code to ASCII map; 0x00 means "not a character".
module ps2_keymap
  import ps2_defs::*;
#(
  parameter logic [7:0] ENTER_CHAR = 8'h0a
) (
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic       upper;

  assign upper = shift ^ caps;

  // Letters resolved to lowercase first so the case flip is a single subtract
  always_comb begin
    letter = ASCII_NUL;
    case (scancode)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = ASCII_NUL;
    endcase
  end

  // Non-letter keys; digits and punctuation follow shift only, never caps
  always_comb begin
    ascii = ASCII_NUL;
    if (letter != ASCII_NUL) begin
      ascii = upper ? (letter - 8'h20) : letter;
    end else begin
      case (scancode)
        8'h16: ascii = shift ? 8'h21 : 8'h31;
        8'h1E: ascii = shift ? 8'h40 : 8'h32;
        8'h26: ascii = shift ? 8'h23 : 8'h33;
        8'h25: ascii = shift ? 8'h24 : 8'h34;
        8'h2E: ascii = shift ? 8'h25 : 8'h35;
        8'h36: ascii = shift ? 8'h5E : 8'h36;
        8'h3D: ascii = shift ? 8'h26 : 8'h37;
        8'h3E: ascii = shift ? 8'h2A : 8'h38;
        8'h46: ascii = shift ? 8'h28 : 8'h39;
        8'h45: ascii = shift ? 8'h29 : 8'h30;
        8'h29: ascii = ASCII_SPACE;
        SC_ENTER: ascii = ENTER_CHAR;
        8'h66: ascii = ASCII_BS;
        8'h4E: ascii = shift ? 8'h5F : 8'h2D;
        8'h49: ascii = shift ? 8'h3E : 8'h2E;
        8'h41: ascii = shift ? 8'h3C : 8'h2C;
        default: ascii = ASCII_NUL;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 byte stream to ASCII: prefix FSM, Shift/Caps tracking, one-cycle strobe.
module ps2_scancode_decoder
  import ps2_defs::*;
#(
  parameter logic [7:0] ENTER_CHAR = 8'h0a,
  parameter bit         CAPS_EN    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [7:0] ascii_char,
  output logic       key_pressed,
  output logic       caps_lock
);

  state_t     state, state_nxt;
  logic       shift_l, shift_r, caps_held;
  logic       shift_l_nxt, shift_r_nxt, caps_held_nxt, caps_lock_nxt;
  logic       emit;
  logic [7:0] emit_char;
  logic [7:0] map_char;

  ps2_keymap #(.ENTER_CHAR(ENTER_CHAR)) u_keymap (
    .scancode (ps2_key_data),
    .shift    (shift_l | shift_r),
    .caps     (caps_lock),
    .ascii    (map_char)
  );

  // Next state, modifier updates and emit decision for the byte this cycle
  always_comb begin
    state_nxt     = state;
    shift_l_nxt   = shift_l;
    shift_r_nxt   = shift_r;
    caps_held_nxt = caps_held;
    caps_lock_nxt = caps_lock;
    emit          = 1'b0;
    emit_char     = map_char;
    if (ps2_key_pressed) begin
      if (ps2_key_data == SC_EXT) begin
        // E0 always (re)starts an extended sequence, even mid-prefix
        state_nxt = ST_EXT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ps2_key_data == SC_BREAK) begin
              state_nxt = ST_BRK;
            end else begin
              case (ps2_key_data)
                SC_LSHIFT: shift_l_nxt = 1'b1;
                SC_RSHIFT: shift_r_nxt = 1'b1;
                SC_CAPS: begin
                  // Typematic repeats of Caps must not re-toggle
                  if (CAPS_EN && !caps_held) caps_lock_nxt = ~caps_lock;
                  caps_held_nxt = 1'b1;
                end
                default: emit = (map_char != ASCII_NUL);
              endcase
            end
          end
          ST_BRK: begin
            if (ps2_key_data != SC_BREAK) begin
              state_nxt = ST_IDLE;
              case (ps2_key_data)
                SC_LSHIFT: shift_l_nxt   = 1'b0;
                SC_RSHIFT: shift_r_nxt   = 1'b0;
                SC_CAPS:   caps_held_nxt = 1'b0;
                default: ;
              endcase
            end
          end
          ST_EXT: begin
            if (ps2_key_data == SC_BREAK) begin
              state_nxt = ST_EXT_BRK;
            end else begin
              state_nxt = ST_IDLE;
              if (ps2_key_data == SC_ENTER) begin
                emit      = 1'b1;
                emit_char = ENTER_CHAR;
              end
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // State, flags and output registers; ascii_char holds between strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      caps_held   <= 1'b0;
      caps_lock   <= 1'b0;
      key_pressed <= 1'b0;
      ascii_char  <= ASCII_NUL;
    end else begin
      state       <= state_nxt;
      shift_l     <= shift_l_nxt;
      shift_r     <= shift_r_nxt;
      caps_held   <= caps_held_nxt;
      caps_lock   <= caps_lock_nxt;
      key_pressed <= emit;
      if (emit) ascii_char <= emit_char;
    end
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly upstream of the keyboard line-assembly stage.
- Consumes raw PS/2 Set-2 scan-code bytes from the PS/2 controller and tracks make/break/extended prefixes and Shift/Caps state.
- Emits one ASCII byte plus a one-cycle key_pressed strobe per printable/control key make.
- Output 0x00 is never strobed, so the downstream character counter advances only on real characters.

Parameters:
- ENTER_CHAR, 8'h0a, ASCII emitted for Enter and keypad Enter; it acts as the downstream line terminator.
- CAPS_EN, 1, when 0 Caps Lock is ignored and caps_lock stays 0.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- ps2_key_data  in  8  scan-code byte from the PS/2 controller.
- ps2_key_pressed  in  1  one-cycle strobe: ps2_key_data is valid this cycle.
- ascii_char  out  8  decoded character; holds its last value between strobes.
- key_pressed  out  1  one-cycle pulse: ascii_char is valid this cycle.
- caps_lock  out  1  current Caps Lock state, for an LED or debug.

Behaviour:
- Reset: ascii_char=0x00, key_pressed=0, caps_lock=0, shift_l=0, shift_r=0, caps_held=0, FSM=IDLE.
- Reset has priority over any byte arriving in the same cycle.
- A byte is consumed only in cycles where ps2_key_pressed=1. FSM and flags are otherwise frozen, and key_pressed=0 in any cycle without a consumed byte.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: 0xF0 -> BRK. 0xE0 -> EXT. Any other byte is a make: decode, then stay in IDLE.
  - BRK: byte is a break code. Apply break effects -> IDLE. Never emits.
  - EXT: 0xF0 -> EXT_BRK. 0x5A emits ENTER_CHAR -> IDLE. Any other byte is ignored -> IDLE.
  - EXT_BRK: any byte -> IDLE, no emit.
  - A stray 0xE0 while in BRK/EXT/EXT_BRK goes to EXT. A stray 0xF0 while in BRK stays in BRK.
- Latency: key_pressed rises the cycle after the strobe carrying the final byte, is high exactly one cycle, and ascii_char updates in that same cycle.
- Modifiers:
  - Make 0x12 sets shift_l; make 0x59 sets shift_r. The matching break clears it.
  - shift = shift_l | shift_r. Modifiers never emit.
- Caps Lock (0x58):
  - On make with caps_held=0: caps_lock toggles, then caps_held=1.
  - Typematic repeats while held do not toggle.
  - Break 0x58 clears caps_held. Never emits.
- Keymap (combinational, make codes only):
  - Letters a-z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. Output uppercase when shift XOR caps_lock, else lowercase.
  - Digits 1-9,0: 16 1E 26 25 2E 36 3D 3E 46 45. Shift gives ! @ # $ % ^ & * ( ). Caps Lock does not affect digits.
  - Space 0x29 -> 0x20. Enter 0x5A -> ENTER_CHAR. Backspace 0x66 -> 0x08.
  - 0x4E -> '-' or '_' (shift). 0x49 -> '.' or '>'. 0x41 -> ',' or '<'.
  - Any other code maps to 0x00 and is suppressed: no strobe, ascii_char unchanged.
- Typematic repeat: a repeated make of a held key emits again.
- Mid-sequence reset: a prefix in progress is discarded, and the next byte is treated as starting from IDLE.

Decomposition:
- Shared package ps2_defs holds:
  - Prefix constants SC_BREAK=8'hF0, SC_EXT=8'hE0.
  - Modifier codes SC_LSHIFT, SC_RSHIFT, SC_CAPS, SC_ENTER.
  - ASCII constants ASCII_NUL, ASCII_BS, ASCII_SPACE.
  - The FSM state encoding.
- Sub-module ps2_keymap is purely combinational: inputs (scancode, shift, caps) -> output ascii (0x00 = unmapped).
- The top level holds the FSM, modifier flags and output registers.

Test Plan:
- Reset, then strobe 0x1C -> one cycle later key_pressed=1 for one cycle, ascii_char=0x61; caps_lock=0.
- 0x12, 0x1C, F0 12, 0x1C -> exactly two pulses, 0x41 then 0x61; no pulse for the 0x12 or F0 12 bytes.
- 0x58, 0x58 (repeat), F0 58, 0x1C -> caps_lock=1 after the first 0x58 only; pulse 0x41. Adding shift (0x12) then 0x1C -> 0x61.
- E0 5A -> pulse with ascii_char=0x0A. E0 75 and E0 F0 75 -> no pulses; FSM returns to IDLE, and a following 0x16 gives 0x31.
- F0 1C and unmapped 0x05 -> no pulse, ascii_char unchanged. Back-to-back strobes 0x33,0x43 on consecutive cycles -> pulses on consecutive cycles, 0x68 then 0x69.
- Strobe 0xF0, assert reset for 1 cycle, then 0x1C -> pulse 0x61. Reset asserted the same cycle as a strobe -> no pulse, all outputs at reset values.
